// File: rtl/gate_chk_seq_pkg.sv
// Shared definitions for the gate-stage stimulus/check sequencer.
package gate_chk_seq_pkg;

    localparam int unsigned NVEC   = 4;
    localparam int unsigned VEC_W  = 2;
    localparam int unsigned ERR_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned MASK_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Mismatch bits {a,b,c} of the three implementations against x AND y.
    function automatic logic [MASK_W-1:0] mism_mask(
        input logic [VEC_W-1:0] vec,
        input logic             a,
        input logic             b,
        input logic             c
    );
        logic exp_and;
        exp_and = vec[1] & vec[0];
        return {a ^ exp_and, b ^ exp_and, c ^ exp_and};
    endfunction

endpackage

// File: rtl/gate_chk_seq_if.sv
// Run-control handshake and result bus of the gate-stage sequencer.
interface gate_chk_seq_if;
    import gate_chk_seq_pkg::*;

    logic                start;
    logic                busy;
    logic                done;
    logic                pass;
    logic [ERR_W-1:0]    err_cnt;
    logic [VEC_W-1:0]    fail_vec;
    logic [MASK_W-1:0]   fail_mask;

    modport master (
        output start,
        input  busy, done, pass, err_cnt, fail_vec, fail_mask
    );

    modport slave (
        input  start,
        output busy, done, pass, err_cnt, fail_vec, fail_mask
    );

endinterface

// File: rtl/gate_chk_vec_cnt.sv
// Vector counter and settle down-counter for the gate-stage sequencer.
module gate_chk_vec_cnt
    import gate_chk_seq_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             adv,
    output logic [VEC_W-1:0] vec,
    output logic             last_vec_c,
    output logic             settle_done_c
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt;

    // Load restarts at vector 0, advance steps the vector; both reload the settle count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec <= '0;
            cnt <= '0;
        end else if (load) begin
            vec <= '0;
            cnt <= RELOAD;
        end else if (adv) begin
            vec <= vec + VEC_W'(1);
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last_vec_c    = (vec == VEC_W'(NVEC - 1));
    assign settle_done_c = (cnt == '0);

endmodule

// File: rtl/gate_chk_seq.sv
// Stimulus-and-check sequencer around the two-input AND gate stage.
// Optional feature: define GATE_CHK_CAPTURE_EN to capture the first failing
// vector and its mismatch bits; otherwise fail_vec/fail_mask read as zero.
module gate_chk_seq
    import gate_chk_seq_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    gate_chk_seq_if.slave   ctl,
    output logic            x,
    output logic            y,
    input  logic            a_in,
    input  logic            b_in,
    input  logic            c_in
);

    state_e              state;
    logic [VEC_W-1:0]    vec;
    logic                last_c;
    logic                expired_c;
    logic                load_c;
    logic                adv_c;
    logic [MASK_W-1:0]   mism_c;
    logic [ERR_W-1:0]    err_nxt_c;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [ERR_W-1:0]    err_cnt_q;

    assign load_c    = (state == ST_IDLE) && ctl.start;
    assign adv_c     = (state == ST_CHECK) && !last_c;
    assign mism_c    = mism_mask(vec, a_in, b_in, c_in);
    assign err_nxt_c = err_cnt_q + ERR_W'(mism_c != '0);

    gate_chk_vec_cnt #(
        .SETTLE (SETTLE)
    ) u_vec_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load_c),
        .adv           (adv_c),
        .vec           (vec),
        .last_vec_c    (last_c),
        .settle_done_c (expired_c)
    );

    // Run FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ctl.start) begin
                        busy_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        err_cnt_q <= '0;
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (expired_c) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    err_cnt_q <= err_nxt_c;
                    if (last_c) begin
                        pass_q <= (err_nxt_c == '0);
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef GATE_CHK_CAPTURE_EN
    logic [VEC_W-1:0]  fail_vec_q;
    logic [MASK_W-1:0] fail_mask_q;

    // Capture only the first failing vector of a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_vec_q  <= '0;
            fail_mask_q <= '0;
        end else if (load_c) begin
            fail_vec_q  <= '0;
            fail_mask_q <= '0;
        end else if ((state == ST_CHECK) && (mism_c != '0) && (err_cnt_q == '0)) begin
            fail_vec_q  <= vec;
            fail_mask_q <= mism_c;
        end
    end

    assign ctl.fail_vec  = fail_vec_q;
    assign ctl.fail_mask = fail_mask_q;
`else
    assign ctl.fail_vec  = '0;
    assign ctl.fail_mask = '0;
`endif

    assign ctl.busy    = busy_q;
    assign ctl.done    = done_q;
    assign ctl.pass    = pass_q;
    assign ctl.err_cnt = err_cnt_q;
    assign x           = vec[1];
    assign y           = vec[0];

endmodule

// File: tb/tb_gate_chk_seq.sv
// Scoreboard bench: two sequencers (SETTLE=1 and SETTLE=3) around a
// fault-injectable gate-stage model, checked against a run-level reference.
module tb_gate_chk_seq;
    import gate_chk_seq_pkg::*;

    localparam int S0 = 1;
    localparam int S1 = 3;
`ifdef GATE_CHK_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_chk_seq_if if0();
    gate_chk_seq_if if1();

    logic x0, y0, a0, b0, c0;
    logic x1, y1, a1, b1, c1;

    // Per-DUT, per-vector {a,b,c} flip pattern applied to the ideal AND.
    logic [2:0] fm [2][4];

    assign a0 = (x0 & y0) ^ fm[0][{x0, y0}][2];
    assign b0 = (x0 & y0) ^ fm[0][{x0, y0}][1];
    assign c0 = (x0 & y0) ^ fm[0][{x0, y0}][0];
    assign a1 = (x1 & y1) ^ fm[1][{x1, y1}][2];
    assign b1 = (x1 & y1) ^ fm[1][{x1, y1}][1];
    assign c1 = (x1 & y1) ^ fm[1][{x1, y1}][0];

    gate_chk_seq #(.SETTLE(S0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ctl(if0),
        .x(x0), .y(y0), .a_in(a0), .b_in(b0), .c_in(c0)
    );

    gate_chk_seq #(.SETTLE(S1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ctl(if1),
        .x(x1), .y(y1), .a_in(a1), .b_in(b1), .c_in(c1)
    );

    typedef struct {
        int         err;
        logic       ps;
        logic [1:0] fv;
        logic [2:0] fmk;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int active [2];
    int rs [2];
    int last_xy [2];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference outcome of one run from the injected flip pattern.
    function automatic exp_t predict(input int d);
        exp_t e;
        e.err = 0;
        e.fv  = 2'b00;
        e.fmk = 3'b000;
        for (int v = 0; v < 4; v++) begin
            if (fm[d][v] != 3'b000) begin
                if (e.err == 0 && CAP) begin
                    e.fv  = 2'(v);
                    e.fmk = fm[d][v];
                end
                e.err++;
            end
        end
        e.ps = (e.err == 0);
        return e;
    endfunction

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d: got %0d expected %0d", nm, d, cyc, act, exp);
        end
    endtask

    task automatic mon(input int d, input int s, input logic xv, input logic yv,
                       input logic bz, input logic dn, input logic ps,
                       input logic [2:0] ec, input logic [1:0] fv,
                       input logic [2:0] fmk, input logic st);
        int   t;
        int   ev;
        int   run_len;
        bit   exp_done;
        exp_t e;
        t = 0;
        run_len = 4 * (s + 1);
        if (active[d] != 0) begin
            t = cyc - rs[d];
            if (t > run_len) begin
                active[d]  = 0;
                last_xy[d] = 3;
            end
        end
        chk("busy", d, int'(bz), (active[d] != 0) ? 1 : 0);
        if (active[d] != 0) ev = ((t / (s + 1)) > 3) ? 3 : (t / (s + 1));
        else                ev = last_xy[d];
        chk("xy", d, int'({xv, yv}), ev);
        exp_done = (active[d] != 0) && (t == run_len);
        chk("done", d, int'(dn), int'(exp_done));
        if (exp_done && dn) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                chk("scoreboard_empty", d, 1, 0);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk("err_cnt", d, int'(ec), e.err);
                chk("pass", d, int'(ps), int'(e.ps));
                chk("fail_vec", d, int'(fv), int'(e.fv));
                chk("fail_mask", d, int'(fmk), int'(e.fmk));
            end
        end
        // Start is accepted at the next edge only when the sequencer is idle.
        if (st && active[d] == 0) begin
            active[d] = 1;
            rs[d]     = cyc + 1;
            if (d == 0) q0.push_back(predict(0));
            else        q1.push_back(predict(1));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, S0, x0, y0, if0.busy, if0.done, if0.pass, if0.err_cnt,
                if0.fail_vec, if0.fail_mask, if0.start);
            mon(1, S1, x1, y1, if1.busy, if1.done, if1.pass, if1.err_cnt,
                if1.fail_vec, if1.fail_mask, if1.start);
        end
    end

    task automatic chk_rst(input int d, input logic xv, input logic yv,
                           input logic bz, input logic dn, input logic ps,
                           input logic [2:0] ec, input logic [1:0] fv,
                           input logic [2:0] fmk);
        chk("rst_x", d, int'(xv), 0);
        chk("rst_y", d, int'(yv), 0);
        chk("rst_busy", d, int'(bz), 0);
        chk("rst_done", d, int'(dn), 0);
        chk("rst_pass", d, int'(ps), 0);
        chk("rst_err_cnt", d, int'(ec), 0);
        chk("rst_fail_vec", d, int'(fv), 0);
        chk("rst_fail_mask", d, int'(fmk), 0);
    endtask

    task automatic chk_rst_both();
        chk_rst(0, x0, y0, if0.busy, if0.done, if0.pass, if0.err_cnt, if0.fail_vec, if0.fail_mask);
        chk_rst(1, x1, y1, if1.busy, if1.done, if1.pass, if1.err_cnt, if1.fail_vec, if1.fail_mask);
    endtask

    task automatic set_all(input int d, input logic [2:0] m);
        for (int v = 0; v < 4; v++) fm[d][v] = m;
    endtask

    function automatic logic [2:0] rmask();
        return ($urandom_range(0, 1) != 0) ? 3'b000 : 3'($urandom_range(1, 7));
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while ((active[0] != 0 || active[1] != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("idle_timeout", 0, (n < 400) ? 1 : 0, 1);
    endtask

    task automatic run_both(input int hold);
        @(posedge clk);
        #1;
        if0.start = 1'b1;
        if1.start = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        if0.start = 1'b0;
        if1.start = 1'b0;
        wait_idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            set_all(d, 3'b000);
            active[d]  = 0;
            rs[d]      = 0;
            last_xy[d] = 0;
        end
        if0.start = 1'b0;
        if1.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk_rst_both();

        // All implementations correct.
        run_both(1);

        // c stuck at 0: only vector 11 fails, on c.
        set_all(0, 3'b000);
        set_all(1, 3'b000);
        fm[0][3] = 3'b001;
        fm[1][3] = 3'b001;
        run_both(1);

        // b inverted: every vector fails, on b.
        set_all(0, 3'b010);
        set_all(1, 3'b010);
        run_both(1);

        // Start held high: one run per idle window, results cleared per run.
        for (int d = 0; d < 2; d++)
            for (int v = 0; v < 4; v++) fm[d][v] = rmask();
        run_both(20);

        // Reset between edges 5 and 6 of a run.
        set_all(0, 3'b000);
        set_all(1, 3'b000);
        @(posedge clk);
        #1;
        if0.start = 1'b1;
        if1.start = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        if1.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_rst_both();
        for (int d = 0; d < 2; d++) begin
            active[d]  = 0;
            last_xy[d] = 0;
        end
        q0.delete();
        q1.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        run_both(1);

        // Randomized flip patterns and start hold lengths.
        for (int r = 0; r < 12; r++) begin
            for (int d = 0; d < 2; d++)
                for (int v = 0; v < 4; v++) fm[d][v] = rmask();
            run_both(int'($urandom_range(1, 3)));
        end

        chk("q0_drained", 0, q0.size(), 0);
        chk("q1_drained", 1, q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
